// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART receive path.
//   - word_len_e : number of data bits per character (5..8)
//   - rx_trig_e  : RX FIFO interrupt trigger level (1, 4, 8 or 14 entries)
//   - rx_err_s   : per-character error flags reported by the receiver
//   - helpers    : trigger-level decode and character-timeout tick limit
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        WL_5 = 2'b00,
        WL_6 = 2'b01,
        WL_7 = 2'b10,
        WL_8 = 2'b11
    } word_len_e;

    typedef enum logic [1:0] {
        TRIG_1  = 2'b00,
        TRIG_4  = 2'b01,
        TRIG_8  = 2'b10,
        TRIG_14 = 2'b11
    } rx_trig_e;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic break_int;
    } rx_err_s;

    // Character times of silence before a character-timeout is raised.
    localparam int RX_TIMEOUT_CHARS = 4;
    // div_clk_en runs at 16x the baud rate.
    localparam int TICKS_PER_BIT    = 16;
    // Stored entry: {break, frame, parity, data[7:0]}.
    localparam int RX_ENTRY_W       = 11;
    // Width of the timeout tick counter; the worst case (8 data + parity)
    // is 4 * 16 * 11 = 704 ticks, which fits.
    localparam int RX_TIMEOUT_W     = 10;

    function automatic logic [4:0] rx_trig_depth(input rx_trig_e trig);
        logic [4:0] depth;
        case (trig)
            TRIG_1:  depth = 5'd1;
            TRIG_4:  depth = 5'd4;
            TRIG_8:  depth = 5'd8;
            default: depth = 5'd14;
        endcase
        return depth;
    endfunction

    // Ticks in RX_TIMEOUT_CHARS character times:
    // 16 * (start + data bits + parity + stop) per character.
    function automatic logic [RX_TIMEOUT_W-1:0] rx_timeout_ticks(input word_len_e wl,
                                                                input logic      parity_en);
        int bits;
        bits = 1 + (5 + int'(wl)) + int'(parity_en) + 1;
        return RX_TIMEOUT_W'(bits * TICKS_PER_BIT * RX_TIMEOUT_CHARS);
    endfunction

endpackage

// File: rtl/uart_rx_buffer_ctrl_if.sv
// ----------------------------------------------------------------------------
// uart_rx_buffer_ctrl_if
//   Character strobe bundle from uart_rx into the receive buffer controller.
//   - rx_valid : one-cycle strobe, a character is present
//   - rx_data  : received character, zero-extended to 8 bits
//   - rx_err   : {parity_err, frame_err, break_int}, valid with rx_valid
//   master = receiver side, slave = buffer controller side.
// ----------------------------------------------------------------------------
interface uart_rx_buffer_ctrl_if;
    import uart_pkg::*;

    logic       rx_valid;
    logic [7:0] rx_data;
    rx_err_s    rx_err;

    modport master (output rx_valid, output rx_data, output rx_err);
    modport slave  (input  rx_valid, input  rx_data, input  rx_err);

endinterface

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//   Generic synchronous show-ahead FIFO.
//   - push/wr_data : write an entry (accepted when not full, or when a pop
//                    happens in the same cycle)
//   - pop          : discard the head entry (ignored when empty)
//   - clr          : synchronous flush, wins over push and pop
//   - rd_data      : head entry, combinational; zero when empty
//   - count        : occupancy 0..DEPTH
//   Full is detected from the count, so pointers can wrap freely.
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             clr,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop  && (count_q != '0) && !clr;
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop) && !clr;

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // visible once count covers it, so its power-up contents never leak out.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    // On a push+pop when full, wr_ptr equals rd_ptr: the old head is read
    // here before the edge and overwritten at the edge, which is intended.
    assign rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count   = count_q;

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_buffer_ctrl
//   16550-style receive buffer: RX FIFO (or single holding register when
//   FIFO mode is off), line-status bits and receive interrupt requests.
//   Ports:
//   - clk, rst_n           : clock, asynchronous active-low reset
//   - rx_if (slave)        : rx_valid / rx_data / rx_err from uart_rx
//   - div_clk_en           : 16x baud tick, drives the character timeout
//   - cfg_fifo_en          : 1 = FIFO mode, 0 = single holding register
//   - cfg_trig_level       : irq_rx_data threshold in FIFO mode
//   - cfg_word_len,
//     cfg_parity_en        : character framing, sets the timeout length
//   - fifo_clr             : synchronous flush pulse
//   - rd_en                : RBR read, pops the head
//   - lsr_rd               : LSR read, clears sticky overrun
//   - rd_data, rx_count    : head character (show-ahead) and occupancy
//   - data_ready .. fifo_err : LSR bits 0-4 and 7
//   - irq_rx_data, irq_timeout, irq_line_status : interrupt requests
// ----------------------------------------------------------------------------
module uart_rx_buffer_ctrl
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    uart_rx_buffer_ctrl_if.slave    rx_if,
    input  logic                    div_clk_en,
    input  logic                    cfg_fifo_en,
    input  rx_trig_e                cfg_trig_level,
    input  word_len_e               cfg_word_len,
    input  logic                    cfg_parity_en,
    input  logic                    fifo_clr,
    input  logic                    rd_en,
    input  logic                    lsr_rd,
    output logic [7:0]              rd_data,
    output logic [CNT_W-1:0]        rx_count,
    output logic                    data_ready,
    output logic                    overrun_err,
    output logic                    parity_err,
    output logic                    frame_err,
    output logic                    break_int,
    output logic                    fifo_err,
    output logic                    irq_rx_data,
    output logic                    irq_timeout,
    output logic                    irq_line_status
);

    logic                    fifo_en_q, fifo_en_d;
    logic                    overrun_q, overrun_d;
    logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
    logic [RX_TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                    tmo_q, tmo_d;

    logic [RX_ENTRY_W-1:0]   wr_entry;
    logic [RX_ENTRY_W-1:0]   head;
    logic [CNT_W-1:0]        count;
    logic                    empty, eff_full, flush;
    logic                    push_ok, pop_ok, ovr_set;
    logic                    push_flagged, pop_flagged;
    logic [RX_TIMEOUT_W-1:0] tmo_limit;

    // A mode change flushes the buffer just like fifo_clr does.
    assign flush    = fifo_clr || (cfg_fifo_en != fifo_en_q);
    assign empty    = (count == '0);
    // In holding-register mode the buffer is full as soon as it holds one.
    assign eff_full = cfg_fifo_en ? (count == CNT_W'(DEPTH)) : !empty;

    assign pop_ok   = rd_en && !empty && !flush;
    assign push_ok  = rx_if.rx_valid && !flush && (!eff_full || pop_ok);
    assign ovr_set  = rx_if.rx_valid && !flush && eff_full && !pop_ok;

    assign wr_entry = {rx_if.rx_err.break_int, rx_if.rx_err.frame_err,
                       rx_if.rx_err.parity_err, rx_if.rx_data};

    assign push_flagged = push_ok && (rx_if.rx_err != '0);
    assign pop_flagged  = pop_ok  && (head[10:8] != 3'b000);
    assign tmo_limit    = rx_timeout_ticks(cfg_word_len, cfg_parity_en);

    uart_rx_fifo #(
        .WIDTH (RX_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_ok),
        .wr_data (wr_entry),
        .pop     (pop_ok),
        .clr     (flush),
        .rd_data (head),
        .count   (count)
    );

    always_comb begin
        fifo_en_d = cfg_fifo_en;

        // A set in the same cycle as an LSR read keeps the bit set, so the
        // new overrun is not lost.
        overrun_d = ovr_set || (overrun_q && !lsr_rd);

        err_cnt_d = err_cnt_q;
        if (flush) begin
            err_cnt_d = '0;
        end else begin
            case ({push_flagged, pop_flagged})
                2'b10:   err_cnt_d = err_cnt_q + CNT_W'(1);
                2'b01:   err_cnt_d = err_cnt_q - CNT_W'(1);
                default: err_cnt_d = err_cnt_q;
            endcase
        end

        // Character timeout: counts idle ticks while data sits in the FIFO.
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = tmo_q;
        if (!cfg_fifo_en || flush || push_ok || pop_ok || empty) begin
            tmo_cnt_d = '0;
            tmo_d     = 1'b0;
        end else if (tmo_cnt_q >= tmo_limit) begin
            // Saturated; also covers a framing change that shortens the limit.
            tmo_d = 1'b1;
        end else if (div_clk_en) begin
            tmo_cnt_d = tmo_cnt_q + RX_TIMEOUT_W'(1);
            if (tmo_cnt_d >= tmo_limit) tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_en_q <= 1'b0;
            overrun_q <= 1'b0;
            err_cnt_q <= '0;
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            fifo_en_q <= fifo_en_d;
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign rd_data         = head[7:0];
    assign rx_count        = count;
    assign data_ready      = !empty;
    assign parity_err      = data_ready && head[8];
    assign frame_err       = data_ready && head[9];
    assign break_int       = data_ready && head[10];
    assign overrun_err     = overrun_q;
    assign fifo_err        = (err_cnt_q != '0);

    assign irq_rx_data     = cfg_fifo_en ? (count >= CNT_W'(rx_trig_depth(cfg_trig_level)))
                                         : data_ready;
    assign irq_timeout     = tmo_q;
    assign irq_line_status = overrun_err || parity_err || frame_err || break_int;

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_buffer_ctrl
//   Scoreboard bench: each accepted character is queued as its expected
//   {break, frame, parity, data} entry when driven, and compared against the
//   show-ahead head when it is read back.
// ----------------------------------------------------------------------------
module tb_uart_rx_buffer_ctrl;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             div_clk_en;
    logic             cfg_fifo_en;
    rx_trig_e         cfg_trig_level;
    word_len_e        cfg_word_len;
    logic             cfg_parity_en;
    logic             fifo_clr;
    logic             rd_en;
    logic             lsr_rd;
    logic [7:0]       rd_data;
    logic [CNT_W-1:0] rx_count;
    logic             data_ready, overrun_err, parity_err, frame_err, break_int, fifo_err;
    logic             irq_rx_data, irq_timeout, irq_line_status;

    uart_rx_buffer_ctrl_if rx_if ();

    uart_rx_buffer_ctrl #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_if           (rx_if),
        .div_clk_en      (div_clk_en),
        .cfg_fifo_en     (cfg_fifo_en),
        .cfg_trig_level  (cfg_trig_level),
        .cfg_word_len    (cfg_word_len),
        .cfg_parity_en   (cfg_parity_en),
        .fifo_clr        (fifo_clr),
        .rd_en           (rd_en),
        .lsr_rd          (lsr_rd),
        .rd_data         (rd_data),
        .rx_count        (rx_count),
        .data_ready      (data_ready),
        .overrun_err     (overrun_err),
        .parity_err      (parity_err),
        .frame_err       (frame_err),
        .break_int       (break_int),
        .fifo_err        (fifo_err),
        .irq_rx_data     (irq_rx_data),
        .irq_timeout     (irq_timeout),
        .irq_line_status (irq_line_status)
    );

    always #5 clk = ~clk;

    // Model state
    logic [10:0] sb[$];
    bit          m_ovr;
    bit          m_fifo_en;
    int          n_cmp;
    int          n_mis;

    localparam rx_err_s NO_ERR  = '{parity_err: 1'b0, frame_err: 1'b0, break_int: 1'b0};
    localparam rx_err_s FRM_ERR = '{parity_err: 1'b0, frame_err: 1'b1, break_int: 1'b0};
    localparam rx_err_s PAR_ERR = '{parity_err: 1'b1, frame_err: 1'b0, break_int: 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_entry(input logic [7:0] d, input rx_err_s e);
        return {e.break_int, e.frame_err, e.parity_err, d};
    endfunction

    function automatic bit model_full();
        return m_fifo_en ? (sb.size() == DEPTH) : (sb.size() != 0);
    endfunction

    task automatic send(input logic [7:0] d, input rx_err_s e);
        bit full;
        full = model_full();
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = d;
        rx_if.rx_err   = e;
        cycle();
        rx_if.rx_valid = 1'b0;
        rx_if.rx_err   = NO_ERR;
        if (full) m_ovr = 1'b1;
        else      sb.push_back(mk_entry(d, e));
    endtask

    // Compare the show-ahead head against the scoreboard, then pop it.
    task automatic read_check(input string tag);
        logic [10:0] exp;
        exp = (sb.size() != 0) ? sb[0] : 11'h000;
        check({tag, ".rd_data"}, 32'(rd_data), 32'(exp[7:0]));
        check({tag, ".flags"}, 32'({break_int, frame_err, parity_err}), 32'(exp[10:8]));
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
    endtask

    task automatic read_lsr();
        lsr_rd = 1'b1;
        cycle();
        lsr_rd = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic push_pop(input logic [7:0] d);
        logic [10:0] exp;
        exp = (sb.size() != 0) ? sb[0] : 11'h000;
        check("pp.rd_data", 32'(rd_data), 32'(exp[7:0]));
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = d;
        rx_if.rx_err   = NO_ERR;
        rd_en          = 1'b1;
        cycle();
        rx_if.rx_valid = 1'b0;
        rd_en          = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
        sb.push_back(mk_entry(d, NO_ERR));
    endtask

    task automatic set_mode(input bit en);
        cfg_fifo_en = en;
        m_fifo_en   = en;
        cycle();
        sb.delete();
    endtask

    // One character stored, then idle ticks until the timeout must fire.
    task automatic tmo_test(input string tag, input word_len_e wl, input bit par, input int ticks);
        cfg_word_len  = wl;
        cfg_parity_en = par;
        send(8'hA0 + 8'(ticks[3:0]), NO_ERR);
        div_clk_en = 1'b1;
        repeat (ticks - 1) cycle();
        check({tag, ".before"}, 32'(irq_timeout), 32'd0);
        cycle();
        check({tag, ".at"}, 32'(irq_timeout), 32'd1);
        repeat (20) cycle();
        check({tag, ".sat"}, 32'(irq_timeout), 32'd1);
        div_clk_en = 1'b0;
        read_check(tag);
        check({tag, ".clr"}, 32'(irq_timeout), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        m_ovr = 1'b0;
        rst_n          = 1'b0;
        div_clk_en     = 1'b0;
        cfg_fifo_en    = 1'b1;
        m_fifo_en      = 1'b1;
        cfg_trig_level = TRIG_4;
        cfg_word_len   = WL_8;
        cfg_parity_en  = 1'b0;
        fifo_clr       = 1'b0;
        rd_en          = 1'b0;
        lsr_rd         = 1'b0;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        rx_if.rx_err   = NO_ERR;

        // Reset state
        repeat (2) cycle();
        check("rst.rx_count", 32'(rx_count), 32'd0);
        check("rst.lsr", 32'({fifo_err, break_int, frame_err, parity_err, overrun_err, data_ready}), 32'd0);
        check("rst.irq", 32'({irq_rx_data, irq_timeout, irq_line_status}), 32'd0);
        check("rst.rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) cycle();

        // Trigger level 4 in FIFO mode
        send(8'h11, NO_ERR);
        send(8'h22, NO_ERR);
        send(8'h33, NO_ERR);
        check("trig.count3", 32'(rx_count), 32'd3);
        check("trig.irq3", 32'(irq_rx_data), 32'd0);
        send(8'h44, NO_ERR);
        check("trig.irq4", 32'(irq_rx_data), 32'd1);
        for (int i = 0; i < 4; i++) read_check("trig.rd");
        check("trig.dr", 32'(data_ready), 32'd0);
        check("trig.empty_rd", 32'(rd_data), 32'd0);

        // Fill, overrun, LSR clear
        for (int i = 0; i < DEPTH; i++) send(8'(8'h80 + i), NO_ERR);
        check("full.count", 32'(rx_count), 32'(DEPTH));
        send(8'hEE, NO_ERR);
        check("ovr.set", 32'(overrun_err), 32'(m_ovr));
        check("ovr.count", 32'(rx_count), 32'(DEPTH));
        check("ovr.irq_ls", 32'(irq_line_status), 32'd1);
        read_lsr();
        check("ovr.clr", 32'(overrun_err), 32'(m_ovr));

        // Push and pop together on a full FIFO
        push_pop(8'h5A);
        check("pp.count", 32'(rx_count), 32'(DEPTH));
        check("pp.ovr", 32'(overrun_err), 32'd0);
        for (int i = 0; i < 3; i++) read_check("pp.rd");
        check("pp.count13", 32'(rx_count), 32'(DEPTH - 3));

        // Clear concurrent with a push
        fifo_clr       = 1'b1;
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = 8'h77;
        cycle();
        fifo_clr       = 1'b0;
        rx_if.rx_valid = 1'b0;
        sb.delete();
        check("clr.count", 32'(rx_count), 32'd0);
        check("clr.dr", 32'(data_ready), 32'd0);

        // Flagged entry between clean ones
        send(8'h10, NO_ERR);
        send(8'h55, FRM_ERR);
        send(8'h20, PAR_ERR);
        send(8'h30, NO_ERR);
        check("err.fifo_err0", 32'(fifo_err), 32'd1);
        check("err.frame_nothead", 32'(frame_err), 32'd0);
        read_check("err.rd0");
        check("err.frame_head", 32'(frame_err), 32'd1);
        check("err.irq_ls", 32'(irq_line_status), 32'd1);
        read_check("err.rd1");
        check("err.fifo_err_par", 32'(fifo_err), 32'd1);
        read_check("err.rd2");
        check("err.fifo_err_done", 32'(fifo_err), 32'd0);
        read_check("err.rd3");

        // Character timeout
        tmo_test("tmo8n1", WL_8, 1'b0, 640);
        tmo_test("tmo7n1", WL_7, 1'b0, 576);
        tmo_test("tmo7e1", WL_7, 1'b1, 640);
        cfg_word_len  = WL_8;
        cfg_parity_en = 1'b0;

        // Non-FIFO holding register
        set_mode(1'b0);
        send(8'hC1, NO_ERR);
        send(8'hC2, NO_ERR);
        check("nf.ovr", 32'(overrun_err), 32'(m_ovr));
        check("nf.count", 32'(rx_count), 32'd1);
        check("nf.irq", 32'(irq_rx_data), 32'd1);
        check("nf.dr", 32'(data_ready), 32'd1);
        read_check("nf.rd");
        check("nf.irq_after", 32'(irq_rx_data), 32'd0);
        read_lsr();

        // Asynchronous reset mid-operation
        send(8'hD1, NO_ERR);
        send(8'hD2, NO_ERR);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.count", 32'(rx_count), 32'd0);
        check("arst.ovr", 32'(overrun_err), 32'd0);
        check("arst.rd_data", 32'(rd_data), 32'd0);
        cycle();
        rst_n = 1'b1;
        sb.delete();
        m_ovr = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
